cpe_adder_arbiter: RTL and testbench

- Shares one CPE-protected adder datapath between two requesters. The datapath is the adder plus its linear/codeword stage, producing the 15-bit CPE codeword.
- Arbitrates round-robin, drives the operands, waits a fixed datapath latency and captures the codeword.
- Checks the codeword's parity bits and its data bits against a golden sum, then returns the code and an error flag to the granted requester.
- Sits between the client logic and the protected adder, and keeps a saturating error count for test and diagnosis.

---
 rtl/cpe_adder_arbiter_if.sv | 37 +++
 rtl/cpe_adder_arbiter.sv | 120 ++++++++++++
 tb/tb_cpe_adder_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpe_adder_arbiter_if.sv
// Request/response handshakes for both clients plus the shared adder datapath port.
interface cpe_adder_arbiter_if #(
  parameter int NBIT  = 7,
  parameter int NCODE = 15
);
  logic             req0_valid;
  logic [NBIT-1:0]  req0_a;
  logic [NBIT-1:0]  req0_b;
  logic             req0_ready;
  logic             rsp0_valid;
  logic [NCODE-1:0] rsp0_code;
  logic             rsp0_err;

  logic             req1_valid;
  logic [NBIT-1:0]  req1_a;
  logic [NBIT-1:0]  req1_b;
  logic             req1_ready;
  logic             rsp1_valid;
  logic [NCODE-1:0] rsp1_code;
  logic             rsp1_err;

  logic [NBIT-1:0]  add_a;
  logic [NBIT-1:0]  add_b;
  logic [NCODE-1:0] add_code;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, add_code,
    output req0_ready, rsp0_valid, rsp0_code, rsp0_err,
           req1_ready, rsp1_valid, rsp1_code, rsp1_err, add_a, add_b
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, add_code,
    input  req0_ready, rsp0_valid, rsp0_code, rsp0_err,
           req1_ready, rsp1_valid, rsp1_code, rsp1_err, add_a, add_b
  );
endinterface

// File: rtl/cpe_adder_arbiter.sv
// Round-robin arbiter sharing one CPE-protected adder between two clients;
// checks each returned codeword and keeps a saturating error count.
module cpe_adder_arbiter #(
  parameter int NBIT   = 7,
  parameter int NCODE  = 15,
  parameter int LAT    = 1,
  parameter int ECNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  cpe_adder_arbiter_if.slave bus,
  output logic              busy,
  output logic [ECNT_W-1:0] err_count
);
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t           state, state_nxt;
  logic             last_grant, grant, grant_r, accept;
  logic [CNT_W-1:0] cnt;
  logic [NBIT-1:0]  add_a_r, add_b_r, sum, s;
  logic [NCODE-NBIT-1:0] par;
  logic             err_now, err_r;
  logic [NCODE-1:0] code0_r, code1_r;
  logic             err0_r, err1_r;

  // Contention goes to whoever was not served last; a lone request wins outright.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
    else if (bus.req1_valid)              grant = 1'b1;
    accept = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Parity rows of the CPE code, plus the golden sum for the data bits.
  always_comb begin
    sum    = add_a_r + add_b_r;
    s      = bus.add_code[NBIT-1:0];
    par[0] = s[0] ^ s[1] ^ s[3];
    par[1] = s[1] ^ s[2] ^ s[4];
    par[2] = s[2] ^ s[3] ^ s[5];
    par[3] = s[3] ^ s[4] ^ s[6];
    par[4] = s[0] ^ s[1] ^ s[3] ^ s[4] ^ s[5];
    par[5] = s[1] ^ s[2] ^ s[4] ^ s[5] ^ s[6];
    par[6] = s[0] ^ s[1] ^ s[2] ^ s[5] ^ s[6];
    par[7] = s[0] ^ s[2] ^ s[6];
    err_now = (bus.add_code[NCODE-1:NBIT] != par) || (s != sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_r    <= 1'b0;
      cnt        <= '0;
      add_a_r    <= '0;
      add_b_r    <= '0;
      err_r      <= 1'b0;
      code0_r    <= '0;
      code1_r    <= '0;
      err0_r     <= 1'b0;
      err1_r     <= 1'b0;
      err_count  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            add_a_r    <= grant ? bus.req1_a : bus.req0_a;
            add_b_r    <= grant ? bus.req1_b : bus.req0_b;
            grant_r    <= grant;
            last_grant <= grant;
            cnt        <= CNT_W'(LAT - 1);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            err_r <= err_now;
            if (grant_r) begin
              code1_r <= bus.add_code;
              err1_r  <= err_now;
            end else begin
              code0_r <= bus.add_code;
              err0_r  <= err_now;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (err_r && (err_count != '1)) err_count <= err_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy           = (state != IDLE);
  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;
  assign bus.rsp0_valid = (state == RESP) && !grant_r;
  assign bus.rsp1_valid = (state == RESP) && grant_r;
  assign bus.rsp0_code  = code0_r;
  assign bus.rsp1_code  = code1_r;
  assign bus.rsp0_err   = err0_r;
  assign bus.rsp1_err   = err1_r;
  assign bus.add_a      = add_a_r;
  assign bus.add_b      = add_b_r;
endmodule

// File: tb/tb_cpe_adder_arbiter.sv
// Bench for cpe_adder_arbiter: randomized traffic against a transaction-level model
// (LAT=1, ECNT_W=8) and a directed reset/saturation run on a second copy (LAT=4, ECNT_W=2).
module tb_cpe_adder_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_m = 1'b0, rst_s = 1'b0;
  logic       busy_m, busy_s;
  logic [7:0] ecnt_m;
  logic [1:0] ecnt_s;

  cpe_adder_arbiter_if #(.NBIT(7), .NCODE(15)) m_if ();
  cpe_adder_arbiter_if #(.NBIT(7), .NCODE(15)) s_if ();

  cpe_adder_arbiter #(.NBIT(7), .NCODE(15), .LAT(1), .ECNT_W(8)) u_dut (
    .clk(clk), .rst(rst_m), .bus(m_if), .busy(busy_m), .err_count(ecnt_m));
  cpe_adder_arbiter #(.NBIT(7), .NCODE(15), .LAT(4), .ECNT_W(2)) u_sat (
    .clk(clk), .rst(rst_s), .bus(s_if), .busy(busy_s), .err_count(ecnt_s));

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference encoder: each parity bit is the XOR of the data bits selected by its row.
  function automatic logic [14:0] cpe_enc(input logic [6:0] d);
    logic [7:0][6:0] rows;
    logic [7:0]      p;
    rows = {7'b1000101, 7'b1100111, 7'b1110110, 7'b0111011,
            7'b1011000, 7'b0101100, 7'b0010110, 7'b0001011};
    for (int i = 0; i < 8; i++) p[i] = ^(d & rows[i]);
    return {p, d};
  endfunction

  function automatic logic [14:0] rand_mask();
    case ($urandom_range(0, 5))
      3:       return 15'(1 << $urandom_range(7, 14));
      4:       return 15'(1 << $urandom_range(0, 6));
      5:       return 15'($urandom) | 15'(1 << $urandom_range(0, 14));
      default: return 15'h0;
    endcase
  endfunction

  // Datapath models: combinational for LAT=1, three registers for LAT=4.
  logic [14:0] m_mask = '0, s_mask = '0;
  logic [14:0] sp0 = '0, sp1 = '0, sp2 = '0;
  assign m_if.add_code = cpe_enc(7'(m_if.add_a + m_if.add_b)) ^ m_mask;
  always @(posedge clk) begin
    sp0 <= cpe_enc(7'(s_if.add_a + s_if.add_b));
    sp1 <= sp0;
    sp2 <= sp1;
  end
  assign s_if.add_code = sp2 ^ s_mask;

  // Main-instance model state
  localparam int MLAT = 1;
  int          cyc = 0, free_cyc = 0, resp_cyc = -1, exp_cnt = 0;
  bit          last_g = 1'b1, resp_who = 1'b0, exp_err = 1'b0;
  logic [14:0] exp_code = '0, h0_code = '0, h1_code = '0;
  bit          h0_err = 1'b0, h1_err = 1'b0;
  bit          p0 = 1'b0, p1 = 1'b0, acc0 = 1'b0, acc1 = 1'b0, rnd = 1'b0, use_force = 1'b0;
  logic [6:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [14:0] force_mask = '0;

  task automatic m_cycle();
    bit g, acc;
    logic [14:0] mk;
    @(negedge clk);
    if (acc0) p0 = 1'b0;
    if (acc1) p1 = 1'b0;
    acc0 = 1'b0; acc1 = 1'b0;
    if (rnd) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin p0 = 1'b1; a0 = 7'($urandom); b0 = 7'($urandom); end
      if (!p1 && $urandom_range(0, 2) != 0) begin p1 = 1'b1; a1 = 7'($urandom); b1 = 7'($urandom); end
    end
    m_if.req0_valid = p0; m_if.req0_a = a0; m_if.req0_b = b0;
    m_if.req1_valid = p1; m_if.req1_a = a1; m_if.req1_b = b1;
    #1;
    if (cyc == resp_cyc) begin
      if (resp_who) begin h1_code = exp_code; h1_err = exp_err; end
      else          begin h0_code = exp_code; h0_err = exp_err; end
    end
    if (cyc == resp_cyc + 1 && exp_err && exp_cnt < 255) exp_cnt++;
    check("rsp0_valid", m_if.rsp0_valid, cyc == resp_cyc && !resp_who);
    check("rsp1_valid", m_if.rsp1_valid, cyc == resp_cyc && resp_who);
    check("rsp0_code", m_if.rsp0_code, h0_code);
    check("rsp1_code", m_if.rsp1_code, h1_code);
    check("rsp0_err", m_if.rsp0_err, h0_err);
    check("rsp1_err", m_if.rsp1_err, h1_err);
    check("err_count", ecnt_m, exp_cnt);
    check("busy", busy_m, cyc < free_cyc);
    acc = (cyc >= free_cyc) && (p0 || p1);
    g   = (p0 && p1) ? !last_g : p1;
    check("req0_ready", m_if.req0_ready, acc && !g);
    check("req1_ready", m_if.req1_ready, acc && g);
    if (acc) begin
      mk       = use_force ? force_mask : rand_mask();
      m_mask   = mk;
      last_g   = g;
      resp_who = g;
      free_cyc = cyc + MLAT + 2;
      resp_cyc = cyc + MLAT + 1;
      exp_code = cpe_enc(g ? 7'(a1 + b1) : 7'(a0 + b0)) ^ mk;
      exp_err  = (mk != 15'h0);
      if (g) acc1 = 1'b1; else acc0 = 1'b0 | 1'b1;
    end
    cyc++;
  endtask

  task automatic m_reset();
    @(negedge clk);
    rst_m = 1'b1;
    p0 = 1'b0; p1 = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
    m_if.req0_valid = 1'b0; m_if.req1_valid = 1'b0;
    @(negedge clk);
    rst_m = 1'b0;
    last_g = 1'b1; free_cyc = 0; resp_cyc = -1; exp_cnt = 0; exp_err = 1'b0;
    h0_code = '0; h1_code = '0; h0_err = 1'b0; h1_err = 1'b0;
  endtask

  // One LAT=4 operation from a single requester; the response must land in cycle 5.
  task automatic s_run(input bit who, input logic [6:0] a, input logic [6:0] b,
                       input logic [14:0] mask);
    logic [14:0] ec;
    @(negedge clk);
    s_mask = mask;
    s_if.req0_valid = !who; s_if.req0_a = a; s_if.req0_b = b;
    s_if.req1_valid = who;  s_if.req1_a = a; s_if.req1_b = b;
    #1;
    check("s_ready", who ? s_if.req1_ready : s_if.req0_ready, 1);
    ec = cpe_enc(7'(a + b)) ^ mask;
    @(negedge clk);
    s_if.req0_valid = 1'b0; s_if.req1_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      check("s_rsp_valid", who ? s_if.rsp1_valid : s_if.rsp0_valid, k == 5);
      check("s_rsp_other", who ? s_if.rsp0_valid : s_if.rsp1_valid, 0);
      if (k == 5) begin
        check("s_rsp_code", who ? s_if.rsp1_code : s_if.rsp0_code, ec);
        check("s_rsp_err", who ? s_if.rsp1_err : s_if.rsp0_err, mask != 15'h0);
      end
    end
    check("s_busy_end", busy_s, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_if.req0_valid = 1'b0; m_if.req0_a = '0; m_if.req0_b = '0;
    m_if.req1_valid = 1'b0; m_if.req1_a = '0; m_if.req1_b = '0;
    s_if.req0_valid = 1'b0; s_if.req0_a = '0; s_if.req0_b = '0;
    s_if.req1_valid = 1'b0; s_if.req1_a = '0; s_if.req1_b = '0;
    #1 rst_m = 1'b1; rst_s = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_add_a", m_if.add_a, 0);
    check("rst_add_b", m_if.add_b, 0);
    check("rst_rsp0", {m_if.rsp0_valid, m_if.rsp0_err, m_if.rsp0_code}, 0);
    check("rst_rsp1", {m_if.rsp1_valid, m_if.rsp1_err, m_if.rsp1_code}, 0);
    check("rst_ecnt", ecnt_m, 0);
    check("rst_busy", busy_m, 0);
    rst_m = 1'b0;

    // Single request 5+3
    p0 = 1'b1; a0 = 7'd5; b0 = 7'd3; use_force = 1'b1; force_mask = '0;
    repeat (4) m_cycle();
    check("code_5_3", m_if.rsp0_code, 15'h0E88);
    check("err_5_3", m_if.rsp0_err, 0);

    // Contention straight after reset: req0 first, then req1
    m_reset();
    p0 = 1'b1; a0 = 7'd1; b0 = 7'd2; p1 = 1'b1; a1 = 7'd3; b1 = 7'd4;
    repeat (8) m_cycle();
    check("both_d0", m_if.rsp0_code[6:0], 3);
    check("both_d1", m_if.rsp1_code[6:0], 7);
    p0 = 1'b1; a0 = 7'd9; b0 = 7'd10; p1 = 1'b1; a1 = 7'd20; b1 = 7'd30;
    repeat (8) m_cycle();

    // Parity bit 9 corrupted
    force_mask = 15'h0200; p0 = 1'b1; a0 = 7'd4; b0 = 7'd4;
    repeat (4) m_cycle();
    check("flip9_err", m_if.rsp0_err, 1);
    check("flip9_cnt", ecnt_m, 1);

    // Data bit 2 flipped with self-consistent parity: only the golden sum catches it
    force_mask = cpe_enc(7'd7) ^ cpe_enc(7'd3); p0 = 1'b1; a0 = 7'd1; b0 = 7'd2;
    repeat (4) m_cycle();
    check("flip2_err", m_if.rsp0_err, 1);
    check("flip2_cnt", ecnt_m, 2);

    // Carry out of the 7-bit sum is not an error
    force_mask = '0; p0 = 1'b1; a0 = 7'd100; b0 = 7'd50;
    repeat (4) m_cycle();
    check("wrap_data", m_if.rsp0_code[6:0], 22);
    check("wrap_err", m_if.rsp0_err, 0);

    use_force = 1'b0; rnd = 1'b1;
    repeat (400) m_cycle();
    rnd = 1'b0;
    repeat (20) m_cycle();

    // Second instance: reset during WAIT discards the operation
    @(negedge clk);
    rst_s = 1'b0;
    @(negedge clk);
    s_if.req0_valid = 1'b1; s_if.req0_a = 7'd10; s_if.req0_b = 7'd11;
    #1 check("s_mid_ready", s_if.req0_ready, 1);
    @(negedge clk);
    s_if.req0_valid = 1'b0;
    @(negedge clk);
    rst_s = 1'b1;
    #1 check("s_mid_busy", busy_s, 0);
    @(negedge clk);
    rst_s = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      check("s_no_rsp", {s_if.rsp0_valid, s_if.rsp1_valid, busy_s}, 0);
    end
    @(negedge clk);
    s_if.req0_valid = 1'b1; s_if.req1_valid = 1'b1;
    #1;
    check("s_lg_r0", s_if.req0_ready, 1);
    check("s_lg_r1", s_if.req1_ready, 0);
    s_if.req0_valid = 1'b0; s_if.req1_valid = 1'b0;
    s_run(1'b1, 7'd60, 7'd70, 15'h0);
    check("s_r1_ecnt", ecnt_s, 0);

    for (int i = 0; i < 5; i++) begin
      s_run(1'b0, 7'(i * 9), 7'(i + 1), 15'h0100);
      check("s_sat_ecnt", ecnt_s, (i + 1 > 3) ? 3 : i + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
